gol_grid: RTL and testbench

- Parametrised Game-of-Life array: a ROWS x COLS grid of cells that all update together, one generation per clock.
- Edge handling is selectable at elaboration: dead edges or toroidal wrap.
- Birth and survival rules are set by parameter masks.
- The grid is loaded row-serially over a valid/ready interface. A small control FSM provides run, stop and single-step operation, a generation counter, and automatic halt on a still pattern.

---
 rtl/gol_grid_if.sv | 31 +++
 rtl/gol_grid.sv | 231 +++++++++++++++++++++++
 tb/tb_gol_grid.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gol_grid_if.sv
// gol_grid_if
//   Row-serial load channel into a gol_grid array. One row is transferred
//   on every cycle where load_valid and load_ready are both high.
//
// Signals:
//   load_valid  master -> slave   load_row carries a valid row
//   load_ready  slave  -> master  the grid accepts a row this cycle
//   load_row    master -> slave   row data, bit c = column c (COLS wide)
//
// Modports:
//   master  the side that produces rows (testbench / host)
//   slave   the grid
interface gol_grid_if #(
    parameter int COLS = 10
);
    logic            load_valid;
    logic            load_ready;
    logic [COLS-1:0] load_row;

    modport master (
        output load_valid,
        output load_row,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_row,
        output load_ready
    );
endinterface

// File: rtl/gol_grid.sv
// gol_grid
//   A ROWS x COLS Game-of-Life array in which every cell computes its next
//   state in parallel, so one full generation is committed per clock.
//   Edges are either dead (WRAP=0) or toroidal (WRAP=1). Birth and survival
//   are selected by 9-bit masks indexed by the live-neighbour count.
//
//   A three-state controller (LOAD, IDLE, RUN) sequences row-serial loading,
//   single stepping and free running. A generation that would not change the
//   grid is not committed; it raises 'stable' and, in RUN, drops back to IDLE.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active low
//   load       gol_grid_if.slave: load_valid / load_ready / load_row[COLS]
//   start      pulse: enter free-running mode (from IDLE)
//   stop       pulse: leave free-running mode
//   step       pulse: compute exactly one generation (from IDLE)
//   cells      grid state, cells[r*COLS+c]
//   running    high while free-running
//   gen_count  generations committed since the last completed load (saturating)
//   stable     the last attempted generation produced no change
//   empty      every cell is dead
module gol_grid #(
    parameter int         ROWS         = 10,
    parameter int         COLS         = 10,
    parameter int         WRAP         = 0,
    parameter logic [8:0] BIRTH_MASK   = 9'b0_0000_1000,
    parameter logic [8:0] SURVIVE_MASK = 9'b0_0000_1100,
    parameter int         GEN_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gol_grid_if.slave            load,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step,
    output logic [ROWS*COLS-1:0] cells,
    output logic                 running,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 empty
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [IDX_W-1:0]   row_idx;
    logic [N-1:0]       cells_q;
    logic [N-1:0]       next_cells;
    logic [GEN_W-1:0]   gen_q;
    logic               stable_q;

    // Control strobes produced by the next-state logic.
    logic               ready_c;
    logic               accept;
    logic               last_row;
    logic               attempt;
    logic               still;

    // ------------------------------------------------------------------
    // Next-generation array.
    // Each cell gathers its eight neighbours. Neighbour coordinates are
    // resolved at elaboration: with wrap they are taken modulo the grid
    // size, without wrap an out-of-range neighbour is tied to zero. The
    // modulo index is always computed so that both modes share one
    // expression; HIT masks it off for dead edges.
    // Neighbour order k: 0..2 row above (left..right), 3 left, 4 right,
    // 5..7 row below (left..right).
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nb;
            logic [3:0] count;

            for (genvar k = 0; k < 8; k++) begin : g_nb
                localparam int DR  = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int DC  = (k == 0 || k == 3 || k == 5) ? -1 :
                                     ((k == 1 || k == 6) ? 0 : 1);
                localparam int RW  = (r + DR + ROWS) % ROWS;
                localparam int CW  = (c + DC + COLS) % COLS;
                localparam bit HIT = (WRAP != 0) ||
                                     ((r + DR) >= 0 && (r + DR) < ROWS &&
                                      (c + DC) >= 0 && (c + DC) < COLS);

                assign nb[k] = HIT & cells_q[RW*COLS + CW];
            end

            // Population count of the eight neighbours, range 0..8.
            always_comb begin
                count = '0;
                for (int k = 0; k < 8; k++) begin
                    count = count + {3'b000, nb[k]};
                end
            end

            // The rule masks are indexed directly by the neighbour count.
            assign next_cells[r*COLS + c] = cells_q[r*COLS + c] ?
                                            SURVIVE_MASK[count] :
                                            BIRTH_MASK[count];
        end
    end

    // A generation that reproduces the current grid is treated as a halt
    // condition rather than committed.
    assign still = (next_cells == cells_q);

    // ------------------------------------------------------------------
    // Controller state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Controller next-state and strobes.
    // In IDLE a load beat takes precedence over start and step, and start
    // takes precedence over step. In RUN stop takes precedence over both
    // the update and the still-pattern halt. row_idx is always zero in
    // IDLE, so a beat accepted there naturally lands in row 0.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ready_c  = 1'b0;
        accept   = 1'b0;
        last_row = 1'b0;
        attempt  = 1'b0;

        case (state_q)
            LOAD: begin
                ready_c = 1'b1;
                if (load.load_valid) begin
                    accept = 1'b1;
                    if (row_idx == IDX_W'(ROWS - 1)) begin
                        last_row = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            IDLE: begin
                ready_c = 1'b1;
                if (load.load_valid) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end else if (start) begin
                    state_d = RUN;
                end else if (step) begin
                    attempt = 1'b1;
                end
            end

            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    attempt = 1'b1;
                    if (still) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grid, row pointer, generation counter and stable flag.
    // A load beat writes one row; a generation attempt either commits the
    // new grid and counts it, or records that the grid is still. The two
    // never coincide because the controller only raises one of them.
    // Completing a load restarts the generation count and clears stable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cells_q  <= '0;
            row_idx  <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (row_idx == IDX_W'(r)) begin
                        cells_q[r*COLS +: COLS] <= load.load_row;
                    end
                end
                row_idx <= last_row ? '0 : row_idx + 1'b1;
            end else if (attempt && !still) begin
                cells_q <= next_cells;
            end

            if (last_row) begin
                gen_q    <= '0;
                stable_q <= 1'b0;
            end else if (attempt) begin
                stable_q <= still;
                // Saturate instead of wrapping so a long run never reads
                // as a freshly loaded grid.
                if (!still && gen_q != '1) begin
                    gen_q <= gen_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign load.load_ready = ready_c;
    assign cells           = cells_q;
    assign running         = (state_q == RUN);
    assign gen_count       = gen_q;
    assign stable          = stable_q;
    assign empty           = (cells_q == '0);

endmodule

// File: tb/tb_gol_grid.sv
// tb_gol_grid
//   Self-checking bench for gol_grid. Three instances share one clock and
//   reset: A = 10x10 dead edges, B = 5x5 toroidal, C = 10x10 toroidal.
//   A behavioural model (grid array, neighbour counting with plain index
//   arithmetic, idle/run mode flag) predicts cells, gen_count, stable and
//   running. Inputs are driven and outputs sampled on the falling edge.
module tb_gol_grid;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gol_grid_if #(.COLS(10)) bus_a ();
    gol_grid_if #(.COLS(5))  bus_b ();
    gol_grid_if #(.COLS(10)) bus_c ();

    logic [2:0]  start_s;
    logic [2:0]  stop_s;
    logic [2:0]  step_s;
    logic [2:0]  running_s;
    logic [2:0]  stable_s;
    logic [2:0]  empty_s;
    logic [99:0] cells_a;
    logic [24:0] cells_b;
    logic [99:0] cells_c;
    logic [15:0] gen_a;
    logic [15:0] gen_b;
    logic [15:0] gen_c;

    gol_grid #(.ROWS(10), .COLS(10), .WRAP(0)) dut_a (
        .clk(clk), .rst(rst), .load(bus_a),
        .start(start_s[0]), .stop(stop_s[0]), .step(step_s[0]),
        .cells(cells_a), .running(running_s[0]), .gen_count(gen_a),
        .stable(stable_s[0]), .empty(empty_s[0])
    );

    gol_grid #(.ROWS(5), .COLS(5), .WRAP(1)) dut_b (
        .clk(clk), .rst(rst), .load(bus_b),
        .start(start_s[1]), .stop(stop_s[1]), .step(step_s[1]),
        .cells(cells_b), .running(running_s[1]), .gen_count(gen_b),
        .stable(stable_s[1]), .empty(empty_s[1])
    );

    gol_grid #(.ROWS(10), .COLS(10), .WRAP(1)) dut_c (
        .clk(clk), .rst(rst), .load(bus_c),
        .start(start_s[2]), .stop(stop_s[2]), .step(step_s[2]),
        .cells(cells_c), .running(running_s[2]), .gen_count(gen_c),
        .stable(stable_s[2]), .empty(empty_s[2])
    );

    int checks   = 0;
    int failures = 0;

    logic [9:0] load_rows [10];

    // Reference model state.
    bit mg [10][10];
    int m_rows;
    int m_cols;
    int m_wrap;
    int m_gen;
    bit m_stable;
    bit m_run;

    // ---------------- instance routing ----------------
    function automatic logic [99:0] cells_of(input int sel);
        case (sel)
            0:       return cells_a;
            1:       return {75'b0, cells_b};
            default: return cells_c;
        endcase
    endfunction

    function automatic logic [15:0] gen_of(input int sel);
        case (sel)
            0:       return gen_a;
            1:       return gen_b;
            default: return gen_c;
        endcase
    endfunction

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return bus_a.load_ready;
            1:       return bus_b.load_ready;
            default: return bus_c.load_ready;
        endcase
    endfunction

    task automatic set_ctrl(input int sel, input logic st, input logic sp, input logic sq);
        start_s[sel] = st;
        stop_s[sel]  = sp;
        step_s[sel]  = sq;
    endtask

    task automatic set_load(input int sel, input logic v, input logic [9:0] row);
        case (sel)
            0: begin bus_a.load_valid = v; bus_a.load_row = row;      end
            1: begin bus_b.load_valid = v; bus_b.load_row = row[4:0]; end
            default: begin bus_c.load_valid = v; bus_c.load_row = row; end
        endcase
    endtask

    // ---------------- reference model ----------------
    function automatic int nbr(input int r, input int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr;
                int cc;
                rr = r + dr;
                cc = c + dc;
                if (dr == 0 && dc == 0) continue;
                if (m_wrap != 0) begin
                    rr = (rr + m_rows) % m_rows;
                    cc = (cc + m_cols) % m_cols;
                end else if (rr < 0 || rr >= m_rows || cc < 0 || cc >= m_cols) begin
                    continue;
                end
                n += int'(mg[rr][cc]);
            end
        end
        return n;
    endfunction

    // Conway B3/S23: birth on exactly 3, survival on 2 or 3.
    task automatic model_attempt();
        bit nx [10][10];
        bit same;
        same = 1'b1;
        nx = mg;
        for (int r = 0; r < m_rows; r++) begin
            for (int c = 0; c < m_cols; c++) begin
                int n;
                n = nbr(r, c);
                nx[r][c] = mg[r][c] ? (n == 2 || n == 3) : (n == 3);
                if (nx[r][c] != mg[r][c]) same = 1'b0;
            end
        end
        if (same) begin
            m_stable = 1'b1;
        end else begin
            mg = nx;
            if (m_gen != 65535) m_gen++;
            m_stable = 1'b0;
        end
    endtask

    // One clock of controller behaviour with no load traffic.
    task automatic model_cycle(input bit st, input bit sp, input bit sq);
        if (m_run) begin
            if (sp) begin
                m_run = 1'b0;
            end else begin
                model_attempt();
                if (m_stable) m_run = 1'b0;
            end
        end else if (st) begin
            m_run = 1'b1;
        end else if (sq) begin
            model_attempt();
        end
    endtask

    function automatic logic [99:0] model_pack();
        logic [99:0] v = '0;
        for (int r = 0; r < m_rows; r++)
            for (int c = 0; c < m_cols; c++)
                v[r*m_cols + c] = mg[r][c];
        return v;
    endfunction

    task automatic clear_rows();
        for (int r = 0; r < 10; r++) load_rows[r] = '0;
    endtask

    task automatic random_rows();
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                load_rows[r][c] = ($urandom_range(0, 2) == 0);
    endtask

    // Streams load_rows into instance sel with random stalls. With noisy
    // set, start/stop/step are toggled while the load is in progress and
    // start+step accompany the very first beat.
    task automatic load_grid(input int sel, input bit noisy);
        m_rows = (sel == 1) ? 5 : 10;
        m_cols = m_rows;
        m_wrap = (sel == 0) ? 0 : 1;
        for (int r = 0; r < m_rows; r++) begin
            int stalls;
            stalls = $urandom_range(0, 2);
            for (int s = 0; s < stalls; s++) begin
                set_load(sel, 1'b0, 10'h3FF);
                if (noisy && r > 0)
                    set_ctrl(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else
                    set_ctrl(sel, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
            end
            set_load(sel, 1'b1, load_rows[r]);
            if (noisy)
                set_ctrl(sel, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
            @(negedge clk);
        end
        set_load(sel, 1'b0, '0);
        set_ctrl(sel, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < m_rows; r++)
            for (int c = 0; c < m_cols; c++)
                mg[r][c] = load_rows[r][c];
        m_gen    = 0;
        m_stable = 1'b0;
        m_run    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            set_ctrl(s, 1'b0, 1'b0, 1'b0);
            set_load(s, 1'b0, '0);
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++; if (cells_of(s) !== '0) begin failures++; $display("[TB] FAIL reset_cells sel=%0d: got %h expected 0", s, cells_of(s)); end
            checks++; if (gen_of(s) !== 16'd0) begin failures++; $display("[TB] FAIL reset_gen sel=%0d: got %0d expected 0", s, gen_of(s)); end
            checks++; if (stable_s[s] !== 1'b0) begin failures++; $display("[TB] FAIL reset_stable sel=%0d: got %b expected 0", s, stable_s[s]); end
            checks++; if (running_s[s] !== 1'b0) begin failures++; $display("[TB] FAIL reset_running sel=%0d: got %b expected 0", s, running_s[s]); end
            checks++; if (ready_of(s) !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready sel=%0d: got %b expected 1", s, ready_of(s)); end
            checks++; if (empty_s[s] !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty sel=%0d: got %b expected 1", s, empty_s[s]); end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_blinker();
        logic [99:0] vert;
        logic [99:0] horiz;
        clear_rows();
        load_rows[4][3] = 1'b1; load_rows[4][4] = 1'b1; load_rows[4][5] = 1'b1;
        vert = '0;  vert[34] = 1'b1;  vert[44] = 1'b1;  vert[54] = 1'b1;
        horiz = '0; horiz[43] = 1'b1; horiz[44] = 1'b1; horiz[45] = 1'b1;
        load_grid(0, 1'b0);
        checks++; if (cells_a !== horiz) begin failures++; $display("[TB] FAIL blinker_loaded: got %h expected %h", cells_a, horiz); end
        checks++; if (empty_s[0] !== 1'b0) begin failures++; $display("[TB] FAIL blinker_empty: got %b expected 0", empty_s[0]); end
        // Two back-to-back step pulses, then a quiet cycle.
        set_ctrl(0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); model_cycle(0, 0, 1);
        checks++; if (cells_a !== model_pack()) begin failures++; $display("[TB] FAIL blinker_step1_model: got %h expected %h", cells_a, model_pack()); end
        checks++; if (cells_a !== vert) begin failures++; $display("[TB] FAIL blinker_step1_vertical: got %h expected %h", cells_a, vert); end
        checks++; if (gen_a !== 16'd1) begin failures++; $display("[TB] FAIL blinker_gen1: got %0d expected 1", gen_a); end
        @(negedge clk); model_cycle(0, 0, 1);
        checks++; if (cells_a !== horiz) begin failures++; $display("[TB] FAIL blinker_step2_horizontal: got %h expected %h", cells_a, horiz); end
        checks++; if (gen_a !== 16'd2) begin failures++; $display("[TB] FAIL blinker_gen2: got %0d expected 2", gen_a); end
        set_ctrl(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); model_cycle(0, 0, 0);
        checks++; if (gen_a !== 16'd2) begin failures++; $display("[TB] FAIL blinker_gen_hold: got %0d expected 2", gen_a); end
        checks++; if (stable_s[0] !== 1'b0) begin failures++; $display("[TB] FAIL blinker_stable: got %b expected 0", stable_s[0]); end
    endtask

    task automatic test_still();
        logic [99:0] blk;
        clear_rows();
        load_rows[0][0] = 1'b1; load_rows[0][1] = 1'b1; load_rows[1][0] = 1'b1; load_rows[1][1] = 1'b1;
        blk = '0; blk[0] = 1'b1; blk[1] = 1'b1; blk[10] = 1'b1; blk[11] = 1'b1;
        load_grid(0, 1'b0);
        set_ctrl(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); model_cycle(1, 0, 0);
        checks++; if (running_s[0] !== 1'b1) begin failures++; $display("[TB] FAIL still_enter_run: got %b expected 1", running_s[0]); end
        set_ctrl(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); model_cycle(0, 0, 0);
        checks++; if (running_s[0] !== 1'b0) begin failures++; $display("[TB] FAIL still_halt: got %b expected 0", running_s[0]); end
        checks++; if (stable_s[0] !== 1'b1) begin failures++; $display("[TB] FAIL still_stable: got %b expected 1", stable_s[0]); end
        checks++; if (gen_a !== 16'd0) begin failures++; $display("[TB] FAIL still_gen: got %0d expected 0", gen_a); end
        checks++; if (cells_a !== blk) begin failures++; $display("[TB] FAIL still_cells: got %h expected %h", cells_a, blk); end
        @(negedge clk); model_cycle(0, 0, 0);
        checks++; if (running_s[0] !== m_run) begin failures++; $display("[TB] FAIL still_stays_idle: got %b expected %b", running_s[0], m_run); end
        // Empty grid: runs for one cycle and halts as still.
        clear_rows();
        load_grid(0, 1'b0);
        checks++; if (empty_s[0] !== 1'b1) begin failures++; $display("[TB] FAIL empty_flag: got %b expected 1", empty_s[0]); end
        set_ctrl(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); model_cycle(1, 0, 0);
        set_ctrl(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); model_cycle(0, 0, 0);
        checks++; if (stable_s[0] !== 1'b1) begin failures++; $display("[TB] FAIL empty_stable: got %b expected 1", stable_s[0]); end
        checks++; if (running_s[0] !== 1'b0) begin failures++; $display("[TB] FAIL empty_halt: got %b expected 0", running_s[0]); end
    endtask

    task automatic test_corners();
        for (int i = 0; i < 2; i++) begin
            int sel;
            logic [99:0] v;
            logic exp0;
            sel  = (i == 0) ? 0 : 2;
            exp0 = (sel == 2) ? 1'b1 : 1'b0;
            clear_rows();
            load_rows[0][9] = 1'b1; load_rows[9][0] = 1'b1; load_rows[9][9] = 1'b1;
            load_grid(sel, 1'b0);
            set_ctrl(sel, 1'b0, 1'b0, 1'b1);
            @(negedge clk); model_cycle(0, 0, 1);
            set_ctrl(sel, 1'b0, 1'b0, 1'b0);
            v = cells_of(sel);
            checks++; if (v[0] !== exp0) begin failures++; $display("[TB] FAIL corner_origin sel=%0d: got %b expected %b", sel, v[0], exp0); end
            checks++; if (v !== model_pack()) begin failures++; $display("[TB] FAIL corner_model sel=%0d: got %h expected %h", sel, v, model_pack()); end
        end
    endtask

    task automatic test_handshake();
        random_rows();
        load_rows[0][0] = 1'b1;
        load_grid(0, 1'b1);
        checks++; if (cells_a !== model_pack()) begin failures++; $display("[TB] FAIL handshake_rows: got %h expected %h", cells_a, model_pack()); end
        checks++; if (gen_a !== 16'd0) begin failures++; $display("[TB] FAIL handshake_gen_clear: got %0d expected 0", gen_a); end
        checks++; if (stable_s[0] !== 1'b0) begin failures++; $display("[TB] FAIL handshake_stable_clear: got %b expected 0", stable_s[0]); end
        checks++; if (running_s[0] !== 1'b0) begin failures++; $display("[TB] FAIL handshake_not_running: got %b expected 0", running_s[0]); end
        checks++; if (bus_a.load_ready !== 1'b1) begin failures++; $display("[TB] FAIL handshake_ready: got %b expected 1", bus_a.load_ready); end
        @(negedge clk);
        checks++; if (running_s[0] !== 1'b0) begin failures++; $display("[TB] FAIL handshake_idle_after: got %b expected 0", running_s[0]); end
    endtask

    task automatic test_glider_wrap();
        clear_rows();
        load_rows[0][1] = 1'b1; load_rows[1][2] = 1'b1;
        load_rows[2][0] = 1'b1; load_rows[2][1] = 1'b1; load_rows[2][2] = 1'b1;
        load_grid(1, 1'b0);
        set_ctrl(1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); model_cycle(1, 0, 0);
        checks++; if (running_s[1] !== 1'b1) begin failures++; $display("[TB] FAIL glider_running: got %b expected 1", running_s[1]); end
        // Offer rows the whole time the grid is free-running.
        set_ctrl(1, 1'b0, 1'b0, 1'b0);
        set_load(1, 1'b1, 10'h3FF);
        for (int i = 0; i < 20; i++) begin
            checks++; if (bus_b.load_ready !== 1'b0) begin failures++; $display("[TB] FAIL glider_ready_low cyc=%0d: got %b expected 0", i, bus_b.load_ready); end
            @(negedge clk); model_cycle(0, 0, 0);
            checks++; if (cells_b !== model_pack()[24:0]) begin failures++; $display("[TB] FAIL glider_cells cyc=%0d: got %h expected %h", i, cells_b, model_pack()); end
        end
        set_load(1, 1'b0, '0);
        set_ctrl(1, 1'b0, 1'b1, 1'b0);
        @(negedge clk); model_cycle(0, 1, 0);
        set_ctrl(1, 1'b0, 1'b0, 1'b0);
        checks++; if (running_s[1] !== 1'b0) begin failures++; $display("[TB] FAIL glider_stopped: got %b expected 0", running_s[1]); end
        checks++; if (gen_b !== 16'd20) begin failures++; $display("[TB] FAIL glider_gen: got %0d expected 20", gen_b); end
        checks++; if (cells_b !== model_pack()[24:0]) begin failures++; $display("[TB] FAIL glider_final: got %h expected %h", cells_b, model_pack()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2; i++) begin
            int sel;
            sel = (i == 0) ? 0 : 2;
            random_rows();
            load_grid(sel, 1'b0);
            for (int n = 0; n < 80; n++) begin
                bit st, sp, sq;
                st = ($urandom_range(0, 7) == 0);
                sp = ($urandom_range(0, 9) == 0);
                sq = ($urandom_range(0, 4) == 0);
                set_ctrl(sel, st, sp, sq);
                @(negedge clk); model_cycle(st, sp, sq);
                checks++; if (cells_of(sel) !== model_pack()) begin failures++; $display("[TB] FAIL random_cells sel=%0d cyc=%0d: got %h expected %h", sel, n, cells_of(sel), model_pack()); end
                checks++; if (gen_of(sel) !== 16'(m_gen)) begin failures++; $display("[TB] FAIL random_gen sel=%0d cyc=%0d: got %0d expected %0d", sel, n, gen_of(sel), m_gen); end
                checks++; if (stable_s[sel] !== m_stable) begin failures++; $display("[TB] FAIL random_stable sel=%0d cyc=%0d: got %b expected %b", sel, n, stable_s[sel], m_stable); end
                checks++; if (running_s[sel] !== m_run) begin failures++; $display("[TB] FAIL random_running sel=%0d cyc=%0d: got %b expected %b", sel, n, running_s[sel], m_run); end
            end
            set_ctrl(sel, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        // Mid-run reset at generation 7.
        clear_rows();
        load_rows[1][2] = 1'b1; load_rows[2][3] = 1'b1;
        load_rows[3][1] = 1'b1; load_rows[3][2] = 1'b1; load_rows[3][3] = 1'b1;
        load_grid(0, 1'b0);
        set_ctrl(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); model_cycle(1, 0, 0);
        set_ctrl(0, 1'b0, 1'b0, 1'b0);
        repeat (7) begin @(negedge clk); model_cycle(0, 0, 0); end
        checks++; if (gen_a !== 16'd7) begin failures++; $display("[TB] FAIL midrun_gen7: got %0d expected 7", gen_a); end
        #2 rst = 1'b0;
        #1;
        checks++; if (cells_a !== '0) begin failures++; $display("[TB] FAIL midrun_rst_cells: got %h expected 0", cells_a); end
        checks++; if (gen_a !== 16'd0) begin failures++; $display("[TB] FAIL midrun_rst_gen: got %0d expected 0", gen_a); end
        checks++; if (bus_a.load_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrun_rst_ready: got %b expected 1", bus_a.load_ready); end
        checks++; if (running_s[0] !== 1'b0) begin failures++; $display("[TB] FAIL midrun_rst_running: got %b expected 0", running_s[0]); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // Mid-load reset after rows 0..3 have been accepted.
        random_rows();
        load_rows[0][0] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            set_load(0, 1'b1, load_rows[r]);
            @(negedge clk);
        end
        set_load(0, 1'b0, '0);
        #2 rst = 1'b0;
        #1;
        checks++; if (cells_a !== '0) begin failures++; $display("[TB] FAIL midload_rst_cells: got %h expected 0", cells_a); end
        checks++; if (bus_a.load_ready !== 1'b1) begin failures++; $display("[TB] FAIL midload_rst_ready: got %b expected 1", bus_a.load_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        random_rows();
        load_rows[0][5] = 1'b1;
        load_grid(0, 1'b0);
        checks++; if (cells_a !== model_pack()) begin failures++; $display("[TB] FAIL reload_after_rst: got %h expected %h", cells_a, model_pack()); end
        checks++; if (gen_a !== 16'd0) begin failures++; $display("[TB] FAIL reload_gen: got %0d expected 0", gen_a); end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_still();
        test_corners();
        test_handshake();
        test_glider_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
